// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

    localparam int unsigned N_DEF = 4;
    localparam int unsigned CNT_W = $clog2(N_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multi_four_bit_add_nbit.sv
// N-bit ripple-carry adder with carry out, used for the partial-product accumulate.
module add_nbit #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] carry;

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        carry  = '0;
        sum_o  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[N];
    end

endmodule

// File: rtl/multi_four_bit.sv
// Sequential NxN unsigned shift-add multiplier with a 2N-bit registered product.
module multi_four_bit
    import mult_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CW = $clog2(N + 1);

    state_t           state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [2*N-1:0]   acc_q,   acc_d;
    logic [2*N-1:0]   p_q,     p_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic [N-1:0]     addend;
    logic [N-1:0]     sum;
    logic             cout;
    logic             last_iter;

    assign addend    = acc_q[0] ? mcand_q : '0;
    assign last_iter = (cnt_q == CW'(N - 1));

    add_nbit #(.N(N)) u_add (
        .a_i    (acc_q[2*N-1:N]),
        .b_i    (addend),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // State register and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept start only in IDLE, run N iterations, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand capture, shift-add iteration, product update.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{N{1'b0}}, b};
                    cnt_d   = '0;
                end
            end
            CALC: begin
                // Carry out sits at the top so the shift keeps the full N+1-bit sum.
                acc_d = {cout, sum, acc_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (last_iter) p_d = {cout, sum, acc_q[N-1:1]};
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
    end

    assign p = p_q;

endmodule

// File: tb/tb_multi_four_bit.sv
// Self-checking bench for multi_four_bit: directed, exhaustive and randomized-noise scenarios.
module tb_multi_four_bit;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2*N-1:0] p;
    logic         busy;
    logic         done;

    int checks;
    int errors;
    int done_cnt;
    logic [2*N-1:0] p_model;

    multi_four_bit #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse, sampled mid-cycle.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation with start accepted at the next edge; checks the whole cycle-accurate timeline.
    task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv, input bit noise);
        logic [2*N-1:0] expv;
        int d0;
        expv = 8'(av * bv);
        d0   = done_cnt;
        start = 1'b1; a = av; b = bv;
        step();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL accept a=%0d b=%0d: busy=%b done=%b, want busy=1 done=0", av, bv, busy, done);
        end
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (noise) begin
                a = 4'($urandom); b = 4'($urandom); start = 1'($urandom);
            end
            step();
            checks++;
            if (i < 4) begin
                if (busy !== 1'b1 || done !== 1'b0 || p !== p_model) begin
                    errors++;
                    $display("FAIL calc%0d a=%0d b=%0d: busy=%b done=%b p=%0d, want busy=1 done=0 p=%0d",
                             i, av, bv, busy, done, p, p_model);
                end
            end else begin
                if (busy !== 1'b0 || done !== 1'b1 || p !== expv) begin
                    errors++;
                    $display("FAIL result a=%0d b=%0d: busy=%b done=%b p=%0d, want busy=0 done=1 p=%0d",
                             av, bv, busy, done, p, expv);
                end
            end
        end
        p_model = expv;
        if (noise) begin
            a = 4'($urandom); b = 4'($urandom); start = 1'($urandom);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || p !== expv || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL done_fall a=%0d b=%0d: done=%b busy=%b p=%0d pulses=%0d, want done=0 busy=0 p=%0d pulses=1",
                     av, bv, done, busy, p, done_cnt - d0, expv);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (p !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: p=%0d busy=%b done=%b, want 0 0 0", p, busy, done);
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (p !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL reset_release: p=%0d busy=%b done=%b pulses=%0d, want 0 0 0 0", p, busy, done, done_cnt);
        end
        p_model = '0;
    endtask

    task automatic test_max();
        do_op(4'd15, 4'd15, 1'b0);
    endtask

    task automatic test_directed();
        do_op(4'd0,  4'd9,  1'b0);
        do_op(4'd1,  4'd13, 1'b0);
        do_op(4'd12, 4'd1,  1'b0);
        do_op(4'd9,  4'd0,  1'b0);
    endtask

    // Every pair, back-to-back, with random garbage on the inputs while busy.
    task automatic test_back_to_back();
        for (int i = 0; i < 256; i++) begin
            do_op(4'(i >> 4), 4'(i), 1'b1);
        end
    endtask

    task automatic test_start_ignored();
        int d0;
        d0 = done_cnt;
        start = 1'b1; a = 4'd7; b = 4'd6;
        step();
        start = 1'b0; a = 4'($urandom); b = 4'($urandom);
        step();
        start = 1'b1; a = 4'd3; b = 4'd3;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (done !== 1'b1 || p !== 8'd42) begin
            errors++;
            $display("FAIL ignore_result: done=%b p=%0d, want done=1 p=42", done, p);
        end
        repeat (8) step();
        checks++;
        if (done_cnt != d0 + 1 || p !== 8'd42 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_single: pulses=%0d p=%0d busy=%b, want pulses=1 p=42 busy=0", done_cnt - d0, p, busy);
        end
        p_model = 8'd42;
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        start = 1'b1; a = 4'd11; b = 4'd13;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (p !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_now: p=%0d busy=%b done=%b, want 0 0 0", p, busy, done);
        end
        p_model = '0;
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        checks++;
        if (done_cnt != d0 || p !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: pulses=%0d p=%0d busy=%b, want 0 0 0", done_cnt - d0, p, busy);
        end
        do_op(4'd2, 4'd3, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        p_model  = '0;
        test_reset();
        test_max();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
